// File: rtl/final_soc_sysid_checker_if.sv
// Avalon-MM read channel between the sysid checker (master) and the
// system-ID control slave.
//   address, read         : master -> slave request
//   waitrequest           : slave stall
//   readdata, readdatavalid : slave -> master response
interface final_soc_sysid_checker_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              waitrequest;
  logic [31:0]       readdata;
  logic              readdatavalid;

  modport master (
    output address, read,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/final_soc_sysid_checker.sv
// Reads the sysid ID word (offset 0) and timestamp word (offset 4) over
// Avalon-MM and compares them with build-time expected values.
// Ports:
//   clock, reset   : single clock, synchronous active-high reset
//   start          : one-cycle pulse, honoured only in IDLE
//   bus            : Avalon-MM read master (address/read/waitrequest/
//                    readdata/readdatavalid)
//   busy, done     : sequence in progress / one-cycle end pulse
//   pass, id_mismatch, ts_mismatch, timeout : sticky result of last sequence
//   id_value, ts_value : captured words
//
// state   | meaning
// --------+---------------------------------------------------
// IDLE    | waiting for start
// ID_REQ  | read asserted at BASE_ADDR
// ID_WAIT | ID accepted, waiting for readdatavalid (USE_RDV=1)
// TS_REQ  | read asserted at BASE_ADDR+4
// TS_WAIT | TS accepted, waiting for readdatavalid (USE_RDV=1)
// FINISH  | results valid, done pulse, back to IDLE
module final_soc_sysid_checker #(
  parameter int                ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
  parameter logic [31:0]       EXPECTED_ID    = 32'd0,
  parameter logic [31:0]       EXPECTED_TS    = 32'd1460325513,
  parameter bit                USE_RDV        = 1'b0,
  parameter int                TIMEOUT_CYCLES = 1024
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  final_soc_sysid_checker_if.master bus,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic                      id_mismatch,
  output logic                      ts_mismatch,
  output logic                      timeout,
  output logic [31:0]               id_value,
  output logic [31:0]               ts_value
);

  typedef enum logic [2:0] {
    IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, FINISH
  } state_t;

  // Wraps modulo 2^ADDR_W.
  localparam logic [ADDR_W-1:0] TS_ADDR  = BASE_ADDR + ADDR_W'(4);
  localparam logic [15:0]       CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  logic [15:0] cnt;
  logic        in_req, in_wait, accept, cap_id, cap_ts, expire;

  always_comb begin
    in_req  = (state == ID_REQ) || (state == TS_REQ);
    in_wait = (state == ID_WAIT) || (state == TS_WAIT);
    accept  = in_req && !bus.waitrequest;
    if (USE_RDV) begin
      cap_id = (state == ID_WAIT) && bus.readdatavalid;
      cap_ts = (state == TS_WAIT) && bus.readdatavalid;
    end else begin
      cap_id = (state == ID_REQ) && accept;
      cap_ts = (state == TS_REQ) && accept;
    end
    // An accept without data (USE_RDV=1) on the last allowed cycle still
    // counts as a timeout: the data could not arrive in budget.
    expire = (in_req || in_wait) && (cnt == CNT_LAST) && !(cap_id || cap_ts);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ID_REQ;
      ID_REQ:  if (expire) state_next = FINISH;
               else if (accept) state_next = USE_RDV ? ID_WAIT : TS_REQ;
      ID_WAIT: if (expire) state_next = FINISH;
               else if (cap_id) state_next = TS_REQ;
      TS_REQ:  if (expire) state_next = FINISH;
               else if (accept) state_next = USE_RDV ? TS_WAIT : FINISH;
      TS_WAIT: if (expire) state_next = FINISH;
               else if (cap_ts) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bus.read    <= 1'b0;
      bus.address <= BASE_ADDR;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_mismatch <= 1'b0;
      ts_mismatch <= 1'b0;
      timeout     <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      state       <= state_next;
      // Outputs are registered from the next state so they line up with it.
      bus.read    <= (state_next == ID_REQ) || (state_next == TS_REQ);
      bus.address <= (state_next == TS_REQ) ? TS_ADDR : BASE_ADDR;
      busy        <= (state_next != IDLE);
      done        <= (state_next == FINISH);

      if ((state_next != state) &&
          ((state_next == ID_REQ) || (state_next == TS_REQ)))
        cnt <= '0;
      else if (in_req || in_wait)
        cnt <= cnt + 16'd1;

      if (state == IDLE && start) begin
        pass        <= 1'b0;
        id_mismatch <= 1'b0;
        ts_mismatch <= 1'b0;
        timeout     <= 1'b0;
      end

      if (cap_id) id_value <= bus.readdata;
      if (cap_ts) ts_value <= bus.readdata;

      // Results are settled on the edge into FINISH so they are visible
      // together with done.
      if (expire) begin
        timeout     <= 1'b1;
        pass        <= 1'b0;
        id_mismatch <= 1'b0;
        ts_mismatch <= 1'b0;
      end else if (cap_ts) begin
        id_mismatch <= (id_value != EXPECTED_ID);
        ts_mismatch <= (bus.readdata != EXPECTED_TS);
        pass        <= (id_value == EXPECTED_ID) && (bus.readdata == EXPECTED_TS);
      end
    end
  end

endmodule

// File: tb/tb_final_soc_sysid_checker.sv
module tb_final_soc_sysid_checker;
  localparam logic [31:0] EXP_TS0 = 32'd1460325513;
  localparam logic [31:0] BASE1   = 32'hFFFF_FFFC;
  localparam logic [31:0] EXP_ID1 = 32'hC0DE_0001;
  localparam logic [31:0] EXP_TS1 = 32'h6650_1234;

  logic clock = 1'b0, reset = 1'b1, start0 = 1'b0, start1 = 1'b0;
  logic busy0, done0, pass0, idm0, tsm0, to0;
  logic busy1, done1, pass1, idm1, tsm1, to1;
  logic [31:0] idv0, tsv0, idv1, tsv1;
  int checks = 0, errors = 0;

  final_soc_sysid_checker_if #(.ADDR_W(32)) bus0 ();
  final_soc_sysid_checker_if #(.ADDR_W(32)) bus1 ();

  final_soc_sysid_checker #(
    .ADDR_W(32), .USE_RDV(1'b0), .TIMEOUT_CYCLES(8)
  ) dut0 (
    .clock(clock), .reset(reset), .start(start0), .bus(bus0),
    .busy(busy0), .done(done0), .pass(pass0), .id_mismatch(idm0),
    .ts_mismatch(tsm0), .timeout(to0), .id_value(idv0), .ts_value(tsv0)
  );

  final_soc_sysid_checker #(
    .ADDR_W(32), .BASE_ADDR(BASE1), .EXPECTED_ID(EXP_ID1), .EXPECTED_TS(EXP_TS1),
    .USE_RDV(1'b1), .TIMEOUT_CYCLES(16)
  ) dut1 (
    .clock(clock), .reset(reset), .start(start1), .bus(bus1),
    .busy(busy1), .done(done1), .pass(pass1), .id_mismatch(idm1),
    .ts_mismatch(tsm1), .timeout(to1), .id_value(idv1), .ts_value(tsv1)
  );

  always #5 clock = ~clock;

  // Zero-latency slave for dut0; runs a fixed 40-cycle window after start.
  task automatic run0(input logic [31:0] idw, input logic [31:0] tsw, input int stall,
                      input bit stuck, input int restart_cyc, output int done_cyc,
                      output int read_cyc, output int done_cnt, output int busy_cyc,
                      output logic [3:0] flags_at_done);
    int st;
    bit pend;
    logic [31:0] paddr;
    done_cyc = -1; read_cyc = 0; done_cnt = 0; busy_cyc = 0; flags_at_done = 4'hx;
    st = 0; pend = 0; paddr = 0;
    @(negedge clock); start0 = 1'b1;
    @(negedge clock); start0 = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      start0 = (cyc == restart_cyc);
      if (pend && !stuck) begin
        checks++;
        if (bus0.read !== 1'b1 || bus0.address !== paddr) begin
          errors++;
          $display("FAIL stall_hold cyc=%0d read=%b addr=%h, expected read=1 addr=%h",
                   cyc, bus0.read, bus0.address, paddr);
        end
      end
      if (bus0.read === 1'b1) begin
        read_cyc++;
        if (!pend) st = stall;
        bus0.waitrequest = stuck || (st > 0);
        if (st > 0) st--;
        if (bus0.waitrequest) bus0.readdata = $urandom;
        else bus0.readdata = (bus0.address == 32'd0) ? idw :
                             (bus0.address == 32'd4) ? tsw : 32'hDEAD_BEEF;
        pend = bus0.waitrequest;
        paddr = bus0.address;
      end else begin
        bus0.waitrequest = stuck;
        bus0.readdata = $urandom;
        pend = 1'b0;
      end
      bus0.readdatavalid = 1'($urandom_range(0, 1));
      if (busy0 === 1'b1) busy_cyc++;
      if (done0 === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          flags_at_done = {pass0, idm0, tsm0, to0};
        end
      end
      @(negedge clock);
    end
    start0 = 1'b0; bus0.waitrequest = 1'b0; bus0.readdatavalid = 1'b0;
  endtask

  // Pipelined slave for dut1 with fixed data latency; strobes junk in IDLE at cycle 0.
  task automatic run1(input logic [31:0] idw, input logic [31:0] tsw, input int stall,
                      input int lat, output int done_cyc, output int done_cnt,
                      output logic [3:0] flags_at_done);
    int st;
    bit pend;
    int due_q[$];
    logic [31:0] dat_q[$];
    done_cyc = -1; done_cnt = 0; flags_at_done = 4'hx; st = 0; pend = 0;
    @(negedge clock); start1 = 1'b1; bus1.readdatavalid = 1'b1; bus1.readdata = $urandom;
    @(negedge clock); start1 = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (bus1.read === 1'b1) begin
        if (!pend) st = stall;
        bus1.waitrequest = (st > 0);
        if (st > 0) st--;
        pend = bus1.waitrequest;
        if (!bus1.waitrequest) begin
          due_q.push_back(cyc + lat);
          dat_q.push_back((bus1.address == BASE1) ? idw :
                          (bus1.address == 32'd0) ? tsw : 32'hDEAD_BEEF);
        end
      end else begin
        bus1.waitrequest = 1'b0;
        pend = 1'b0;
      end
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        bus1.readdatavalid = 1'b1;
        bus1.readdata = dat_q[0];
        void'(due_q.pop_front());
        void'(dat_q.pop_front());
      end else begin
        bus1.readdatavalid = 1'b0;
        bus1.readdata = $urandom;
      end
      if (done1 === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          flags_at_done = {pass1, idm1, tsm1, to1};
        end
      end
      @(negedge clock);
    end
    bus1.readdatavalid = 1'b0; bus1.waitrequest = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({bus0.read, busy0, done0, pass0, idm0, tsm0, to0} !== 7'b0 || bus0.address !== 32'd0) begin
      errors++;
      $display("FAIL reset_ctrl0 read/busy/done/flags=%b addr=%h, expected 0000000 addr=0",
               {bus0.read, busy0, done0, pass0, idm0, tsm0, to0}, bus0.address);
    end
    checks++;
    if (idv0 !== 32'd0 || tsv0 !== 32'd0 || idv1 !== 32'd0 || tsv1 !== 32'd0) begin
      errors++;
      $display("FAIL reset_values id0=%h ts0=%h id1=%h ts1=%h, expected all 0", idv0, tsv0, idv1, tsv1);
    end
    checks++;
    if ({bus1.read, busy1, done1, pass1, idm1, tsm1, to1} !== 7'b0 || bus1.address !== BASE1) begin
      errors++;
      $display("FAIL reset_ctrl1 read/busy/done/flags=%b addr=%h, expected 0000000 addr=%h",
               {bus1.read, busy1, done1, pass1, idm1, tsm1, to1}, bus1.address, BASE1);
    end
  endtask

  // Reference: zero-latency timing 3+2*stall, result from word equality.
  task automatic check0(input string name, input logic [31:0] idw, input logic [31:0] tsw,
                        input int stall, input int restart_cyc);
    int dc, rc, dn, bc;
    logic [3:0] fl, exp_fl;
    run0(idw, tsw, stall, 1'b0, restart_cyc, dc, rc, dn, bc, fl);
    exp_fl = {(idw == 32'd0) && (tsw == EXP_TS0), idw != 32'd0, tsw != EXP_TS0, 1'b0};
    checks++;
    if (dc !== 3 + 2 * stall || dn !== 1 || rc !== 2 + 2 * stall || bc !== 3 + 2 * stall) begin
      errors++;
      $display("FAIL %s_timing done_at=%0d dones=%0d read_cycles=%0d busy_cycles=%0d, expected %0d 1 %0d %0d",
               name, dc, dn, rc, bc, 3 + 2 * stall, 2 + 2 * stall, 3 + 2 * stall);
    end
    checks++;
    if (fl !== exp_fl || {pass0, idm0, tsm0, to0} !== exp_fl) begin
      errors++;
      $display("FAIL %s_flags pass/idm/tsm/to at_done=%b later=%b, expected %b",
               name, fl, {pass0, idm0, tsm0, to0}, exp_fl);
    end
    checks++;
    if (idv0 !== idw || tsv0 !== tsw) begin
      errors++;
      $display("FAIL %s_values id=%h ts=%h, expected id=%h ts=%h", name, idv0, tsv0, idw, tsw);
    end
  endtask

  task automatic test_pass_zero_latency();
    check0("pass0", 32'd0, EXP_TS0, 0, 0);
  endtask

  task automatic test_ts_mismatch();
    check0("ts_mm", 32'd0, 32'h1234_5678, 0, 0);
  endtask

  task automatic test_waitrequest();
    check0("waitreq", 32'd0, EXP_TS0, 3, 0);
  endtask

  task automatic test_random_zero_latency();
    logic [31:0] idw, tsw;
    for (int i = 0; i < 8; i++) begin
      idw = ($urandom_range(0, 2) == 0) ? $urandom : 32'd0;
      tsw = ($urandom_range(0, 2) == 0) ? $urandom : EXP_TS0;
      check0("rand0", idw, tsw, int'($urandom_range(0, 4)), 0);
    end
  endtask

  task automatic test_ignored_start();
    check0("start_busy", 32'd0, EXP_TS0, 1, 2);
    check0("start_finish", 32'h0000_0007, EXP_TS0, 0, 3);
  endtask

  task automatic test_timeout();
    int dc, rc, dn, bc;
    logic [3:0] fl;
    check0("pre_to", 32'd0, EXP_TS0, 0, 0);
    run0(32'h1111_1111, 32'h2222_2222, 0, 1'b1, 0, dc, rc, dn, bc, fl);
    checks++;
    if (rc !== 8 || dc !== 9 || dn !== 1) begin
      errors++;
      $display("FAIL timeout_timing read_cycles=%0d done_at=%0d dones=%0d, expected 8 9 1", rc, dc, dn);
    end
    checks++;
    if (fl !== 4'b0001 || {pass0, idm0, tsm0, to0} !== 4'b0001) begin
      errors++;
      $display("FAIL timeout_flags at_done=%b later=%b, expected 0001", fl, {pass0, idm0, tsm0, to0});
    end
    checks++;
    if (idv0 !== 32'd0 || tsv0 !== EXP_TS0) begin
      errors++;
      $display("FAIL timeout_retain id=%h ts=%h, expected id=0 ts=%h", idv0, tsv0, EXP_TS0);
    end
  endtask

  // Reference: pipelined timing 3+2*stall+2*lat.
  task automatic test_pipelined();
    int dc, dn, s, l;
    logic [31:0] idw, tsw;
    logic [3:0] fl, exp_fl;
    for (int i = 0; i < 6; i++) begin
      s = (i == 0) ? 0 : int'($urandom_range(0, 3));
      l = (i == 0) ? 2 : int'($urandom_range(1, 4));
      idw = (i > 0 && $urandom_range(0, 2) == 0) ? $urandom : EXP_ID1;
      tsw = (i > 0 && $urandom_range(0, 2) == 0) ? $urandom : EXP_TS1;
      run1(idw, tsw, s, l, dc, dn, fl);
      exp_fl = {(idw == EXP_ID1) && (tsw == EXP_TS1), idw != EXP_ID1, tsw != EXP_TS1, 1'b0};
      checks++;
      if (dc !== 3 + 2 * s + 2 * l || dn !== 1) begin
        errors++;
        $display("FAIL pipe_timing stall=%0d lat=%0d done_at=%0d dones=%0d, expected %0d 1",
                 s, l, dc, dn, 3 + 2 * s + 2 * l);
      end
      checks++;
      if (fl !== exp_fl || idv1 !== idw || tsv1 !== tsw) begin
        errors++;
        $display("FAIL pipe_result flags=%b id=%h ts=%h, expected flags=%b id=%h ts=%h",
                 fl, idv1, tsv1, exp_fl, idw, tsw);
      end
    end
  endtask

  task automatic test_timeout_late_rdv();
    int dc, dn;
    logic [3:0] fl;
    run1(EXP_ID1, EXP_TS1, 0, 1, dc, dn, fl);
    // Data due at cycle 21, after the abort at cycle 17.
    run1(32'hBAD0_BAD0, 32'hBAD1_BAD1, 0, 20, dc, dn, fl);
    checks++;
    if (dc !== 17 || dn !== 1 || fl !== 4'b0001) begin
      errors++;
      $display("FAIL late_rdv_timeout done_at=%0d dones=%0d flags=%b, expected 17 1 0001", dc, dn, fl);
    end
    checks++;
    if (idv1 !== EXP_ID1 || tsv1 !== EXP_TS1 || {pass1, idm1, tsm1, to1} !== 4'b0001) begin
      errors++;
      $display("FAIL late_rdv_ignored id=%h ts=%h flags=%b, expected id=%h ts=%h flags=0001",
               idv1, tsv1, {pass1, idm1, tsm1, to1}, EXP_ID1, EXP_TS1);
    end
  endtask

  task automatic test_reset_mid();
    bit hit;
    hit = 1'b0;
    @(negedge clock); start0 = 1'b1; bus0.waitrequest = 1'b0;
    @(negedge clock); start0 = 1'b0;
    for (int c = 1; c <= 20 && !hit; c++) begin
      if (bus0.read === 1'b1 && bus0.address === 32'd4) begin
        bus0.waitrequest = 1'b1;
        reset = 1'b1;
        hit = 1'b1;
      end else begin
        bus0.waitrequest = 1'b0;
        bus0.readdata = (bus0.address == 32'd0) ? 32'hABCD_0000 : $urandom;
        @(negedge clock);
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reset_mid_reach ts_req seen=0, expected 1");
    end
    @(negedge clock);
    checks++;
    if ({bus0.read, busy0, done0, pass0, idm0, tsm0, to0} !== 7'b0 || idv0 !== 32'd0 ||
        tsv0 !== 32'd0 || bus0.address !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid read/busy/done/flags=%b id=%h ts=%h addr=%h, expected all 0",
               {bus0.read, busy0, done0, pass0, idm0, tsm0, to0}, idv0, tsv0, bus0.address);
    end
    reset = 1'b0;
    bus0.waitrequest = 1'b0;
  endtask

  initial begin
    bus0.waitrequest = 1'b0; bus0.readdata = 32'd0; bus0.readdatavalid = 1'b0;
    bus1.waitrequest = 1'b0; bus1.readdata = 32'd0; bus1.readdatavalid = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    test_reset();
    test_pass_zero_latency();
    test_ts_mismatch();
    test_waitrequest();
    test_random_zero_latency();
    test_ignored_start();
    test_timeout();
    test_pipelined();
    test_timeout_late_rdv();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
